// File: rtl/dom_rand_pkg.sv
// Shared constants for the DOM fresh-randomness source: LFSR taps, seed fallback
// and FSM state encodings.
package dom_rand_pkg;

    localparam int LFSR_W = 32;

    // Taps 32,22,2,1 expressed as zero-based bit indices.
    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    localparam logic [LFSR_W-1:0] SEED_FALLBACK = 32'h1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_WARMUP = 2'(WARMUP);
    localparam logic [1:0] ST_RUN    = 2'(RUN);

    // An all-zero state is the LFSR's lock-up point, so it is never loaded.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? SEED_FALLBACK : s;
    endfunction

endpackage

// File: rtl/dom_rand_gen_lfsr_step.sv
// Combinational multi-step advance of the 32-bit Fibonacci LFSR (taps 32,22,2,1).
// Shared with other mask sources; STEP single steps are unrolled.
module lfsr_step
    import dom_rand_pkg::*;
#(
    parameter int STEP = 2
) (
    input  logic [LFSR_W-1:0] state_in,
    output logic [LFSR_W-1:0] state_out
);

    always_comb begin
        logic [LFSR_W-1:0] s;
        s = state_in;
        for (int i = 0; i < STEP; i++) begin
            s = {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
        end
        state_out = s;
    end

endmodule

// File: rtl/dom_rand_gen.sv
// Refresh-mask source for the DOM GF(2^2) multipliers: seeded LFSR, warm-up, take/valid
// handshake. Define DOM_RAND_HEALTH_EN to add the repetition-count health test.
module dom_rand_gen
    import dom_rand_pkg::*;
#(
    parameter int OUT_W        = 2,
    parameter int NUM_OUT      = 1,
    parameter int WARMUP       = 64,
    parameter int HEALTH_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       seed_valid,
    output logic                       seed_ready,
    input  logic [31:0]                seed_data,
    output logic                       z_valid,
    input  logic                       z_take,
    output logic [OUT_W*NUM_OUT-1:0]   z_data,
    output logic                       health_fail
);

    localparam int STEP  = OUT_W * NUM_OUT;
    localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    logic [1:0]        state_reg;
    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_adv;
    logic [CNT_W-1:0]  warm_cnt_reg;
    logic              z_valid_reg;
    logic              seed_load;
    logic              take;
    logic              health_trip;
    logic [STEP-1:0]   word;

    assign seed_ready = (state_reg != ST_WARMUP);
    assign seed_load  = seed_valid && seed_ready;
    assign take       = z_take && z_valid_reg;
    assign word       = lfsr_reg[STEP-1:0];

    lfsr_step #(
        .STEP(STEP)
    ) u_step (
        .state_in (lfsr_reg),
        .state_out(lfsr_adv)
    );

    // z_valid trails entry into RUN by one edge, so the first word appears the
    // cycle after the last warm-up advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            lfsr_reg     <= '0;
            warm_cnt_reg <= '0;
            z_valid_reg  <= 1'b0;
        end else if (seed_load) begin
            lfsr_reg     <= seed_fix(seed_data);
            warm_cnt_reg <= '0;
            z_valid_reg  <= 1'b0;
            state_reg    <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end else begin
            case (state_reg)
                ST_WARMUP: begin
                    lfsr_reg     <= lfsr_adv;
                    warm_cnt_reg <= warm_cnt_reg + CNT_W'(1);
                    if (warm_cnt_reg == CNT_W'(WARMUP - 1))
                        state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (take)
                        lfsr_reg <= lfsr_adv;
                    if (health_trip) begin
                        state_reg   <= ST_IDLE;
                        z_valid_reg <= 1'b0;
                    end else begin
                        z_valid_reg <= 1'b1;
                    end
                end
                default: z_valid_reg <= 1'b0;
            endcase
        end
    end

`ifdef DOM_RAND_HEALTH_EN
    localparam int REP_W = $clog2(HEALTH_LIMIT + 1);

    logic [REP_W-1:0] rep_cnt_reg;
    logic [REP_W-1:0] rep_cnt_next;
    logic [STEP-1:0]  prev_word_reg;
    logic             health_fail_reg;

    // A zero count means no word has been accepted since the last seed.
    always_comb begin
        rep_cnt_next = rep_cnt_reg;
        if (take)
            rep_cnt_next = (rep_cnt_reg != '0 && word == prev_word_reg)
                         ? rep_cnt_reg + REP_W'(1) : REP_W'(1);
    end

    assign health_trip = take && (rep_cnt_next == REP_W'(HEALTH_LIMIT));
    assign health_fail = health_fail_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_reg     <= '0;
            prev_word_reg   <= '0;
            health_fail_reg <= 1'b0;
        end else if (seed_load) begin
            rep_cnt_reg     <= '0;
            health_fail_reg <= 1'b0;
        end else begin
            rep_cnt_reg <= rep_cnt_next;
            if (take)
                prev_word_reg <= word;
            if (health_trip)
                health_fail_reg <= 1'b1;
        end
    end
`else
    assign health_trip = 1'b0;
    assign health_fail = 1'b0;
`endif

    assign z_valid = z_valid_reg;
    assign z_data  = z_valid_reg ? word : '0;

endmodule

// File: doc/dom_rand_gen.md
# dom_rand_gen

Fresh-randomness source for the masked AES S-box datapath. Produces the per-cycle refresh mask Z consumed by the DOM dependent-input GF(2^2) multipliers, from a seeded 32-bit LFSR that advances a configurable number of bits per consumed word. It sits directly upstream of the multiplier array. It handles seeding, warm-up, a take/valid handshake, mid-run reseeding and an optional online health test.

## Interface
Parameters:
- `OUT_W`, default 2: width of one Z lane, equal to the GF(2^2) element width.
- `NUM_OUT`, default 1: number of Z lanes delivered per word. `STEP = OUT_W*NUM_OUT`, and STEP must be ≤ 32.
- `WARMUP`, default 64: number of discarded advances after each seed load. 0 is legal.
- `HEALTH_LIMIT`, default 16: number of consecutive identical words that trips the health test. Must be ≥ 2.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `seed_valid`, in, 1: seed offer.
- `seed_ready`, out, 1: seed accept.
- `seed_data`, in, 32: seed value.
- `z_valid`, out, 1: z_data holds a fresh, unconsumed word.
- `z_take`, in, 1: consumer takes the word this cycle.
- `z_data`, out, STEP: lane i occupies bits `[i*OUT_W +: OUT_W]`.
- `health_fail`, out, 1: sticky failure flag.

## Operation
- **LFSR**
  - Fibonacci, 32-bit, taps 32,22,2,1.
  - One step: `fb = s[31]^s[21]^s[1]^s[0]`, then `s <= {s[30:0], fb}`.
  - One advance = STEP steps, unrolled into a single cycle.
- **Seeding**
  - A seed load happens when `seed_valid && seed_ready`.
  - A seed of 0 is replaced by `SEED_FALLBACK` (32'h1).
  - A seed load clears `health_fail` and enters WARMUP, or RUN directly if WARMUP=0.
- **FSM**
  - IDLE (unseeded): `seed_ready=1`, `z_valid=0`.
  - WARMUP: advance every cycle, counting to WARMUP; `seed_ready=0`, `z_valid=0`. Go to RUN after the WARMUP-th advance.
  - RUN: `z_valid=1`, `seed_ready=1`. Advance only when `z_take` is high. A seed load in RUN restarts warm-up.
- **Outputs**
  - `z_data = s[STEP-1:0]` in RUN, else all zeros.
  - Words are never repeated: each accepted word triggers exactly one advance.
- **Edge cases**
  - `z_take` while `z_valid=0` is ignored.
  - Simultaneous `z_take` and seed load in RUN: the take completes for the current word, and the seed load wins the state update.

## Timing
- **Reset values:** state IDLE, LFSR 0, warm-up counter 0, `z_valid=0`, `z_data=0`, `seed_ready=1`, `health_fail=0`.
- **Seed to first word:** for a seed accepted at edge k, `z_valid` rises after edge k+WARMUP+1 (the cycle after the final warm-up advance), or after edge k+1 when WARMUP=0.
- **Throughput:** one new word per cycle while `z_take` stays high. `z_data` updates on the edge following a take.
- **Reseed mid-RUN:** `z_valid` falls on the next edge.
- **Reset mid-WARMUP or mid-RUN:** returns to reset values immediately and asynchronously.

## Configuration
- Macro `DOM_RAND_HEALTH_EN`.
- **Defined:** a repetition-count test runs on accepted words.
  - Counter of consecutive equal accepted words, reset on any new seed.
  - When the count reaches HEALTH_LIMIT, on the same edge: `health_fail=1`, FSM goes to IDLE, `z_valid=0`.
  - `health_fail` is sticky until the next seed load.
- **Undefined:** no counter logic; `health_fail` is tied to 0.

## Structure
- **Package `dom_rand_pkg`:** tap constants, `SEED_FALLBACK`, and the FSM state enum (IDLE, WARMUP, RUN).
- **Sub-module `lfsr_step`:** purely combinational, parameter STEP; maps 32-bit state to the 32-bit state after STEP single steps. It is reused by other mask sources.

## Test plan
1. Reset with no seed -> `z_valid=0`, `seed_ready=1`, `z_data=0`, `health_fail=0` indefinitely.
2. STEP=2, WARMUP=0, seed 32'h1, `z_take` held high -> `z_data` sequence 2'b01, 2'b10, 2'b11 (states 0x1, 0x6, 0x1B).
3. Seed 32'h0 -> identical behaviour to seed 32'h1 (fallback).
4. WARMUP=64, seed accepted at edge k -> `z_valid` first high after edge k+65; `seed_ready=0` throughout warm-up.
5. RUN with `z_take` low for 10 cycles -> `z_data` stable, `z_valid=1`; reseed mid-RUN -> `z_valid=0` next cycle, warm-up restarts.
6. `DOM_RAND_HEALTH_EN` defined, internal LFSR forced to a fixed point, HEALTH_LIMIT=16 -> `health_fail=1` and `z_valid=0` on the 16th equal take; a new seed clears `health_fail`.
